// File: rtl/q_stream_deserializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : q_stream_deserializer_pkg                                 |
// | Brief  : Shared constants for the Q-stream deserializer slice:     |
// |          output FSM state encodings and the default word width.    |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
package q_stream_deserializer_pkg;

  // Default number of bits per collected word
  localparam int DEFAULT_WIDTH = 8;

  // Output FSM encodings (single bit, legacy-compatible)
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/q_shift_collector.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : q_shift_collector                                         |
// | Brief  : Shifts the serial bit into a WIDTH-bit register on every  |
// |          enabled edge and strobes word_done on the completing edge |
// |          together with the full word (including the current bit).  |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module q_shift_collector
  import q_stream_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CW        = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_en,
  output logic             word_done,
  output logic [WIDTH-1:0] word,
  output logic [CW-1:0]    bit_cnt
);

  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);
  localparam logic [CW-1:0] c_one  = CW'(1);

  logic [WIDTH-1:0] r_shift;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] w_next_shift;

  // Shift direction selects which end of the word the first bit lands in
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_next_shift = {r_shift[WIDTH-2:0], in_bit};
    end else begin : g_lsb_first
      assign w_next_shift = {in_bit, r_shift[WIDTH-1:1]};
    end
  endgenerate

  // The word is taken from the next-shift value so the completing bit is included
  assign word_done = in_en & (r_cnt == c_last);
  assign word      = w_next_shift;
  assign bit_cnt   = r_cnt;

  // Shift register and bit counter advance only on enabled edges; counter wraps on completion
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (in_en) begin
      r_shift <= w_next_shift;
      r_cnt   <= (r_cnt == c_last) ? '0 : r_cnt + c_one;
    end
  end

endmodule
`default_nettype wire

// File: rtl/q_stream_deserializer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module : q_stream_deserializer                                     |
// | Brief  : Collects the registered serial bit Q into WIDTH-bit words |
// |          and presents them on a valid/ready port with a one-word   |
// |          buffer; words completing while the buffer is full are     |
// |          dropped and flagged in a sticky overflow bit.             |
// | Rev    : 1.0  initial release                                      |
// +--------------------------------------------------------------------+
module q_stream_deserializer
  import q_stream_deserializer_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_bit,
  input  logic                     in_en,
  input  logic                     clr_ovf,
  output logic [WIDTH-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     overflow,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  logic             w_done;
  logic [WIDTH-1:0] w_word;
  logic             w_drop;

  logic [0:0]       r_state;
  logic [WIDTH-1:0] r_data;
  logic             r_ovf;

  q_shift_collector #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST),
    .CW        ($clog2(WIDTH))
  ) u_collector (
    .clk       (clk),
    .rst       (rst),
    .in_bit    (in_bit),
    .in_en     (in_en),
    .word_done (w_done),
    .word      (w_word),
    .bit_cnt   (bit_cnt)
  );

  // A word is dropped only when it completes into a full buffer that is not being drained
  assign w_drop = (r_state == ST_FULL) & ~out_ready & w_done;

  // Output buffer FSM: load on completion, drain on accept, back-to-back reload without a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_data  <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_done) begin
            r_data  <= w_word;
            r_state <= ST_FULL;
          end
        end
        default: begin
          if (out_ready) begin
            if (w_done) begin
              r_data <= w_word;
            end else begin
              r_state <= ST_EMPTY;
            end
          end
        end
      endcase
    end
  end

  // Sticky overflow: a drop on the same edge as a clear keeps the flag set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (clr_ovf) begin
      r_ovf <= 1'b0;
    end
  end

  assign out_data  = r_data;
  assign out_valid = (r_state == ST_FULL);
  assign overflow  = r_ovf;

endmodule
`default_nettype wire
